// File: rtl/flopr_pipe_if.sv
// Handshake bundle for flopr_pipe: upstream valid/ready/data, downstream valid/ready/data, fill level.
// master = the surrounding logic that feeds and drains the pipe; slave = the pipe itself.
interface flopr_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/flopr_pipe.sv
// Elastic pipeline register: DEPTH valid/data stages with a bubble-collapsing valid/ready handshake.
// Define FLOPR_PIPE_FLUSH_EN to add a synchronous flush input that empties every stage.
module flopr_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         reset,
`ifdef FLOPR_PIPE_FLUSH_EN
  input logic         flush,
`endif
  flopr_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             clear;
  logic [OCC_W-1:0] occ_count;

`ifdef FLOPR_PIPE_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // Ready ripples back from the sink: a stage can take new data if it is empty or is emptying.
  assign rdy[DEPTH] = bus.out_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign rdy[gi] = ~valid_reg[gi] | rdy[gi + 1];

      if (gi == 0) begin : g_head
        assign src_valid[gi] = bus.in_valid;
        assign src_data[gi]  = bus.in_data;
      end else begin : g_body
        assign src_valid[gi] = valid_reg[gi - 1];
        assign src_data[gi]  = data_reg[gi - 1];
      end

      // Data only loads with a valid word, so idle stages keep their flops quiet.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= RESET_VAL;
        end else if (clear) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= RESET_VAL;
        end else if (rdy[gi]) begin
          valid_reg[gi] <= src_valid[gi];
          if (src_valid[gi]) begin
            data_reg[gi] <= src_data[gi];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    occ_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_count = occ_count + OCC_W'(valid_reg[i]);
    end
  end

  assign bus.in_ready  = rdy[0] & ~clear;
  assign bus.out_valid = valid_reg[DEPTH-1];
  assign bus.out_data  = data_reg[DEPTH-1];
  assign bus.occupancy = occ_count;
endmodule

// File: tb/tb_flopr_pipe.sv
// Randomised and directed bench for flopr_pipe (DEPTH=3 main instance, DEPTH=1 side instance),
// checked against a queue-of-words positional model of the pipe.
module tb_flopr_pipe;
  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 3;
  localparam logic [7:0] RST_VAL = 8'h5A;

  logic clk;
  logic reset;
  logic flush;
  int   checks;
  int   errors;

  flopr_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  flopr_pipe_if #(.WIDTH(WIDTH), .DEPTH(1))     bus1 ();

  flopr_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RST_VAL)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef FLOPR_PIPE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  flopr_pipe #(.WIDTH(WIDTH), .DEPTH(1), .RESET_VAL(RST_VAL)) dut1 (
    .clk   (clk),
    .reset (reset),
`ifdef FLOPR_PIPE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: words in order (oldest first) with the stage index each one currently sits in.
  int         m_pos[$];
  logic [7:0] m_dat[$];
  logic [7:0] m_last;

  function automatic bit m_ready();
    int prev;
    int np;
    prev = DEPTH;
    if (flush) return 1'b0;
    for (int k = 0; k < m_pos.size(); k++) begin
      if (k == 0 && m_pos[0] == DEPTH - 1 && bus.out_ready) np = DEPTH;
      else np = (m_pos[k] + 1 < prev) ? m_pos[k] + 1 : m_pos[k];
      prev = np;
    end
    return prev > 0;
  endfunction

  function automatic bit m_out_valid();
    return (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
  endfunction

  task automatic tick();
    bit         acc;
    int         prev;
    int         np;
    int         npos[$];
    logic [7:0] ndat[$];
    acc  = m_ready() && bus.in_valid;
    prev = DEPTH;
    if (flush) begin
      m_pos.delete();
      m_dat.delete();
      m_last = RST_VAL;
    end else begin
      for (int k = 0; k < m_pos.size(); k++) begin
        if (k == 0 && m_pos[0] == DEPTH - 1 && bus.out_ready) np = DEPTH;
        else np = (m_pos[k] + 1 < prev) ? m_pos[k] + 1 : m_pos[k];
        prev = np;
        if (np < DEPTH) begin
          npos.push_back(np);
          ndat.push_back(m_dat[k]);
        end
      end
      if (acc) begin
        npos.push_back(0);
        ndat.push_back(bus.in_data);
      end
      m_pos = npos;
      m_dat = ndat;
      if (m_pos.size() > 0 && m_pos[0] == DEPTH - 1) m_last = m_dat[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 4;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_data !== RST_VAL) begin errors++; $display("FAIL reset_out_data got %h want %h", bus.out_data, RST_VAL); end
    if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'hC0 + k), 1'b0);
      tick();
    end
    checks++;
    if (bus.occupancy !== 2'd3) begin errors++; $display("FAIL prefill_occupancy got %0d want 3", bus.occupancy); end
    #3;
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    m_pos.delete();
    m_dat.delete();
    m_last = RST_VAL;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_data !== RST_VAL) begin errors++; $display("FAIL midreset_out_data got %h want %h", bus.out_data, RST_VAL); end
    if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL midreset_occupancy got %0d want 0", bus.occupancy); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid cycle %0d got %b want 0", k, bus.out_valid); end
      tick();
    end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 21; i++) begin
      drive(i < 16, 8'(i + 1), 1'b1);
      #1;
      checks += 4;
      if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL stream_in_ready cycle %0d got %b want %b", i, bus.in_ready, m_ready()); end
      if (bus.out_valid !== m_out_valid()) begin errors++; $display("FAIL stream_out_valid cycle %0d got %b want %b", i, bus.out_valid, m_out_valid()); end
      if (bus.out_data !== m_last) begin errors++; $display("FAIL stream_out_data cycle %0d got %h want %h", i, bus.out_data, m_last); end
      if (bus.occupancy !== 2'(m_pos.size())) begin errors++; $display("FAIL stream_occupancy cycle %0d got %0d want %0d", i, bus.occupancy, m_pos.size()); end
      if (i >= 3 && i <= 18) begin
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap cycle %0d got out_valid %b want 1", i, bus.out_valid); end
        if (bus.out_data !== 8'(i - 2)) begin errors++; $display("FAIL stream_latency cycle %0d got %h want %h", i, bus.out_data, 8'(i - 2)); end
      end
      if (i >= 3 && i <= 16) begin
        checks++;
        if (bus.occupancy !== 2'd3) begin errors++; $display("FAIL stream_steady_occ cycle %0d got %0d want 3", i, bus.occupancy); end
      end
      tick();
    end
    $display("test_streaming done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'hA1 + k), 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready word %0d got %b want 1", k, bus.in_ready); end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'($urandom), 1'b0);
      #1;
      checks += 4;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, bus.in_ready); end
      if (bus.occupancy !== 2'd3) begin errors++; $display("FAIL bp_occupancy cycle %0d got %0d want 3", k, bus.occupancy); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d got %b want 1", k, bus.out_valid); end
      if (bus.out_data !== 8'hA1) begin errors++; $display("FAIL bp_hold cycle %0d got %h want a1", k, bus.out_data); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      #1;
      checks += 2;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid word %0d got %b want 1", k, bus.out_valid); end
      if (bus.out_data !== 8'(8'hA1 + k)) begin errors++; $display("FAIL bp_drain_data word %0d got %h want %h", k, bus.out_data, 8'(8'hA1 + k)); end
      tick();
    end
    checks++;
    if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty got %0d want 0", bus.occupancy); end
    $display("test_backpressure done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_bubble_collapse();
    drive(1'b1, 8'h11, 1'b0); tick();
    drive(1'b0, 8'hEE, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0); tick();
    drive(1'b0, 8'hEE, 1'b0); tick();
    drive(1'b0, 8'hEE, 1'b0); tick();
    checks += 3;
    if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL bubble_occupancy got %0d want 2", bus.occupancy); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got %b want 1", bus.in_ready); end
    if (bus.out_data !== 8'h11) begin errors++; $display("FAIL bubble_head got %h want 11", bus.out_data); end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bubble_second_valid got %b want 1", bus.out_valid); end
    if (bus.out_data !== 8'h22) begin errors++; $display("FAIL bubble_second_data got %h want 22", bus.out_data); end
    tick();
    $display("test_bubble_collapse done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full_simultaneous();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'hB1 + k), 1'b0);
      tick();
    end
    drive(1'b1, 8'h55, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_simul_in_ready got %b want 1", bus.in_ready); end
    tick();
    drive(1'b0, 8'h00, 1'b0);
    #1;
    checks += 2;
    if (bus.occupancy !== 2'd3) begin errors++; $display("FAIL full_simul_occupancy got %0d want 3", bus.occupancy); end
    if (bus.out_data !== 8'hB2) begin errors++; $display("FAIL full_simul_head got %h want b2", bus.out_data); end
    for (int k = 0; k < 3; k++) begin
      logic [7:0] want;
      want = (k == 2) ? 8'h55 : 8'(8'hB2 + k);
      drive(1'b0, 8'h00, 1'b1);
      #1;
      checks++;
      if (bus.out_data !== want) begin errors++; $display("FAIL full_simul_drain word %0d got %h want %h", k, bus.out_data, want); end
      tick();
    end
    $display("test_full_simultaneous done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    int thresh;
    for (int i = 0; i < 400; i++) begin
      thresh = (i < 100) ? 20 : (i < 200) ? 50 : (i < 300) ? 90 : 100;
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) < thresh);
      #1;
      checks += 4;
      if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rand_in_ready cycle %0d got %b want %b", i, bus.in_ready, m_ready()); end
      if (bus.out_valid !== m_out_valid()) begin errors++; $display("FAIL rand_out_valid cycle %0d got %b want %b", i, bus.out_valid, m_out_valid()); end
      if (bus.out_data !== m_last) begin errors++; $display("FAIL rand_out_data cycle %0d got %h want %h", i, bus.out_data, m_last); end
      if (bus.occupancy !== 2'(m_pos.size())) begin errors++; $display("FAIL rand_occupancy cycle %0d got %0d want %0d", i, bus.occupancy, m_pos.size()); end
      tick();
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (DEPTH + 1) tick();
    $display("test_random done checks=%0d errors=%0d", checks, errors);
  endtask

`ifdef FLOPR_PIPE_FLUSH_EN
  task automatic test_flush();
    drive(1'b1, 8'hC1, 1'b0); tick();
    drive(1'b1, 8'hC2, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    checks++;
    if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL flush_setup_occ got %0d want 2", bus.occupancy); end
    flush = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    #1;
    checks += 2;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_cycle_valid got %b want 1", bus.out_valid); end
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    #1;
    checks += 3;
    if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL flush_occupancy got %0d want 0", bus.occupancy); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_data !== RST_VAL) begin errors++; $display("FAIL flush_out_data got %h want %h", bus.out_data, RST_VAL); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped cycle %0d got out_valid %b want 0", k, bus.out_valid); end
    end
    $display("test_flush done checks=%0d errors=%0d", checks, errors);
  endtask
`endif

  task automatic test_depth1();
    drive(1'b0, 8'h00, 1'b1);
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus1.in_valid = (i < 8);
      bus1.in_data  = 8'(i + 1);
      #1;
      if (i < 8) begin
        checks++;
        if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL d1_stream_ready cycle %0d got %b want 1", i, bus1.in_ready); end
      end
      if (i >= 1 && i <= 8) begin
        checks += 2;
        if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL d1_stream_valid cycle %0d got %b want 1", i, bus1.out_valid); end
        if (bus1.out_data !== 8'(i)) begin errors++; $display("FAIL d1_stream_data cycle %0d got %h want %h", i, bus1.out_data, 8'(i)); end
      end
      tick();
    end
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 8'hA1;
    tick();
    bus1.in_data = 8'hA2;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks += 3;
      if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL d1_bp_ready cycle %0d got %b want 0", k, bus1.in_ready); end
      if (bus1.occupancy !== 1'b1) begin errors++; $display("FAIL d1_bp_occupancy cycle %0d got %0d want 1", k, bus1.occupancy); end
      if (bus1.out_data !== 8'hA1) begin errors++; $display("FAIL d1_bp_hold cycle %0d got %h want a1", k, bus1.out_data); end
      tick();
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    #1;
    checks++;
    if (bus1.out_data !== 8'hA1 || bus1.out_valid !== 1'b1) begin errors++; $display("FAIL d1_release got %b/%h want 1/a1", bus1.out_valid, bus1.out_data); end
    tick();
    checks++;
    if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL d1_no_extra got %b want 0", bus1.out_valid); end
    $display("test_depth1 done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    flush  = 1'b0;
    m_last = RST_VAL;
    drive(1'b0, 8'h00, 1'b0);
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 8'h00;
    bus1.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_full_simultaneous();
    test_random();
`ifdef FLOPR_PIPE_FLUSH_EN
    test_flush();
`endif
    test_depth1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
